// File: rtl/draw_letters_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_if
// Brief    : VGA timing/pixel bundle carried between draw stages.
// Revision : 1.0
// ============================================================================
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        hblnk;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport in (
    input hcount, vcount, hsync, hblnk, vsync, vblnk, rgb
  );

  modport out (
    output hcount, vcount, hsync, hblnk, vsync, vblnk, rgb
  );
endinterface
`default_nettype wire

// File: rtl/draw_letters.sv
`default_nettype none
// ============================================================================
// Module   : draw_letters
// Brief    : Realigns the VGA stream to font-ROM latency and paints text
//            foreground pixels. Define DRAW_LETTERS_BG_EN for a solid box.
// Revision : 1.0
// ============================================================================
module draw_letters #(
  parameter int          X_START     = 280,
  parameter int          Y_START     = 104,
  parameter int          TEXT_COLS   = 16,
  parameter int          TEXT_ROWS   = 1,
  parameter int          ROM_LATENCY = 2,
  parameter logic [11:0] FG_COLOR    = 12'hFFF,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_pixels,
  vga_if.in          vga_in,
  vga_if.out         vga_out
);

  localparam int          c_w    = 38;
  localparam logic [10:0] c_x_lo = 11'(X_START);
  localparam logic [10:0] c_x_hi = 11'(X_START + 8 * TEXT_COLS);
  localparam logic [10:0] c_y_lo = 11'(Y_START);
  localparam logic [10:0] c_y_hi = 11'(Y_START + 16 * TEXT_ROWS);

  generate
    if (ROM_LATENCY < 1 || ROM_LATENCY > 4) begin : g_bad_latency
      $error("draw_letters: ROM_LATENCY must be in 1..4");
    end
    if (X_START + 8 * TEXT_COLS > 2047) begin : g_bad_xwin
      $error("draw_letters: horizontal window exceeds 11-bit hcount");
    end
    if (Y_START + 16 * TEXT_ROWS > 2047) begin : g_bad_ywin
      $error("draw_letters: vertical window exceeds 11-bit vcount");
    end
  endgenerate

  // Packed field order: hcount, vcount, hsync, hblnk, vsync, vblnk, rgb.
  logic [c_w-1:0] w_in;
  logic [c_w-1:0] r_pipe [ROM_LATENCY];
  logic [c_w-1:0] r_out;
  logic [c_w-1:0] w_d;

  logic [10:0] w_d_hcount;
  logic [10:0] w_d_vcount;
  logic        w_d_hblnk;
  logic        w_d_vblnk;
  logic [11:0] w_d_rgb;
  logic [2:0]  w_col;
  logic        w_bit;
  logic        w_in_win;
  logic [11:0] w_rgb;

  assign w_in = {vga_in.hcount, vga_in.vcount, vga_in.hsync, vga_in.hblnk,
                 vga_in.vsync, vga_in.vblnk, vga_in.rgb};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LATENCY; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= w_in;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_d        = r_pipe[ROM_LATENCY-1];
  assign w_d_hcount = w_d[37:27];
  assign w_d_vcount = w_d[26:16];
  assign w_d_hblnk  = w_d[14];
  assign w_d_vblnk  = w_d[12];
  assign w_d_rgb    = w_d[11:0];

  assign w_in_win = (w_d_hcount >= c_x_lo) && (w_d_hcount < c_x_hi) &&
                    (w_d_vcount >= c_y_lo) && (w_d_vcount < c_y_hi) &&
                    !w_d_hblnk && !w_d_vblnk;

  // Only the low three bits of (hcount - X_START) matter for the glyph column.
  assign w_col = w_d_hcount[2:0] - c_x_lo[2:0];
  assign w_bit = char_pixels[3'd7 - w_col];

`ifdef DRAW_LETTERS_BG_EN
  always_comb begin
    w_rgb = w_d_rgb;
    if (w_in_win) begin
      w_rgb = w_bit ? FG_COLOR : BG_COLOR;
    end
  end
`else
  logic w_unused_bg;
  assign w_unused_bg = ^BG_COLOR;

  always_comb begin
    w_rgb = w_d_rgb;
    if (w_in_win && w_bit) begin
      w_rgb = FG_COLOR;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= {w_d[37:12], w_rgb};
    end
  end

  assign vga_out.hcount = r_out[37:27];
  assign vga_out.vcount = r_out[26:16];
  assign vga_out.hsync  = r_out[15];
  assign vga_out.hblnk  = r_out[14];
  assign vga_out.vsync  = r_out[13];
  assign vga_out.vblnk  = r_out[12];
  assign vga_out.rgb    = r_out[11:0];

endmodule
`default_nettype wire
